// File: rtl/bp_top_pkg.sv
// Shared definitions for the core-side LCE request arbiter and its output buffer.
// Covers the source tag width, the default buffer entry layout and the entry width helper.
package bp_top_pkg;

    localparam int lce_req_src_width_gp    = 1;
    localparam int lce_req_header_width_gp = 64;
    localparam int lce_req_data_width_gp   = 512;

    // Buffer entry at default widths; the packed order {src, header, data} is the layout used by the FIFO
    typedef struct packed {
        logic [lce_req_src_width_gp-1:0]    src;
        logic [lce_req_header_width_gp-1:0] header;
        logic [lce_req_data_width_gp-1:0]   data;
    } bp_lce_req_entry_t;

    function automatic int lce_req_entry_width(input int header_width, input int data_width);
        return lce_req_src_width_gp + header_width + data_width;
    endfunction

endpackage

// File: rtl/bp_core_lce_req_arbiter_checker.sv
// Simulation-only properties for the LCE request arbiter: one-hot grants,
// no enqueue into a full buffer, and a stable output under backpressure.
module bp_core_lce_req_arbiter_checker #(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 512
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    input logic [1:0]                ready_and_o,
    input logic                      enq_v,
    input logic                      buf_full,
    input logic                      v_o,
    input logic                      ready_and_i,
    input logic                      src_o,
    input logic [header_width_p-1:0] header_o,
    input logic [data_width_p-1:0]   data_o
);

    a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ready_and_o != 2'b11);

    a_no_enq_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(enq_v && buf_full));

    a_out_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (v_o && !ready_and_i) |=> (v_o && $stable(src_o) && $stable(header_o) && $stable(data_o)));

endmodule

// File: rtl/bp_lce_req_two_fifo.sv
// Two-entry registered FIFO with valid/ready_and on both sides and no bypass.
// The ready output depends only on occupancy, so a full buffer never accepts in the cycle it drains.
module bp_lce_req_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_and_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               ready_and_i
);

    logic [1:0][width_p-1:0] mem_r;
    logic                    wptr_r;
    logic                    rptr_r;
    logic [1:0]              count_r;
    logic                    enq_s;
    logic                    deq_s;

    // Handshake decode from occupancy
    always_comb begin
        ready_and_o = (count_r != 2'd2);
        v_o         = (count_r != 2'd0);
        data_o      = mem_r[rptr_r];
        enq_s       = v_i & ready_and_o;
        deq_s       = v_o & ready_and_i;
    end

    // Storage, wrapping 1-bit pointers and occupancy
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_r   <= '0;
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq_s) begin
                mem_r[wptr_r] <= data_i;
                wptr_r        <= ~wptr_r;
            end
            if (deq_s) begin
                rptr_r <= ~rptr_r;
            end
            count_r <= count_r + {1'b0, enq_s} - {1'b0, deq_s};
        end
    end

endmodule

// File: rtl/bp_core_lce_req_arbiter.sv
// Merges the I$ (index 0) and D$ (index 1) LCE request channels onto one NoC port,
// with round-robin or D$-priority arbitration, a registered 2-entry buffer and a conflict counter.
module bp_core_lce_req_arbiter
    import bp_top_pkg::*;
#(
    parameter int header_width_p = 64,
    parameter int data_width_p   = 512,
    parameter int cnt_width_p    = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic                           fixed_priority_i,
    input  logic [1:0][header_width_p-1:0] lce_req_header_i,
    input  logic [1:0][data_width_p-1:0]   lce_req_data_i,
    input  logic [1:0]                     lce_req_v_i,
    output logic [1:0]                     lce_req_ready_and_o,
    output logic [header_width_p-1:0]      lce_req_header_o,
    output logic [data_width_p-1:0]        lce_req_data_o,
    output logic                           lce_req_src_o,
    output logic                           lce_req_v_o,
    input  logic                           lce_req_ready_and_i,
    output logic [cnt_width_p-1:0]         conflict_cnt_o,
    input  logic                           conflict_clr_i
);

    localparam int entry_width_lp = lce_req_entry_width(header_width_p, data_width_p);

    logic [1:0]                grant_s;
    logic                      grant_src_s;
    logic                      enq_v_s;
    logic                      buf_ready_s;
    logic                      buf_full_s;
    logic [entry_width_lp-1:0] enq_entry_s;
    logic [entry_width_lp-1:0] deq_entry_s;
    logic                      rr_ptr_r;
    logic [cnt_width_p-1:0]    conflict_cnt_r;

    // Grant selection; reset level gates readiness so nothing transfers while reset is held
    always_comb begin
        grant_s    = 2'b00;
        buf_full_s = ~buf_ready_s;
        if (!reset_n_i || buf_full_s) begin
            grant_s = 2'b00;
        end else begin
            case (lce_req_v_i)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11:   grant_s = (fixed_priority_i || rr_ptr_r) ? 2'b10 : 2'b01;
                default: grant_s = 2'b00;
            endcase
        end
    end

    // Tag the granted request with its source index and steer it into the buffer
    always_comb begin
        grant_src_s         = grant_s[1];
        enq_v_s             = |grant_s;
        lce_req_ready_and_o = grant_s;
        if (grant_src_s) begin
            enq_entry_s = {1'b1, lce_req_header_i[1], lce_req_data_i[1]};
        end else begin
            enq_entry_s = {1'b0, lce_req_header_i[0], lce_req_data_i[0]};
        end
    end

    bp_lce_req_two_fifo #(
        .width_p (entry_width_lp)
    ) u_buf (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .data_i      (enq_entry_s),
        .v_i         (enq_v_s),
        .ready_and_o (buf_ready_s),
        .data_o      (deq_entry_s),
        .v_o         (lce_req_v_o),
        .ready_and_i (lce_req_ready_and_i)
    );

    // Unpack the head entry for the NoC side
    always_comb begin
        lce_req_src_o    = deq_entry_s[entry_width_lp-1];
        lce_req_header_o = deq_entry_s[header_width_p+data_width_p-1 -: header_width_p];
        lce_req_data_o   = deq_entry_s[data_width_p-1:0];
        conflict_cnt_o   = conflict_cnt_r;
    end

    // Round-robin pointer moves away from whichever source was just served, in both modes
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rr_ptr_r <= 1'b0;
        end else if (enq_v_s) begin
            rr_ptr_r <= ~grant_src_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Saturating conflict counter; clear wins over increment
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            conflict_cnt_r <= '0;
        end else if (conflict_clr_i) begin
            conflict_cnt_r <= '0;
        end else if ((lce_req_v_i == 2'b11) && !buf_full_s && (conflict_cnt_r != {cnt_width_p{1'b1}})) begin
            conflict_cnt_r <= conflict_cnt_r + cnt_width_p'(1);
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    bp_core_lce_req_arbiter_checker #(
        .header_width_p (header_width_p),
        .data_width_p   (data_width_p)
    ) u_chk (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .ready_and_o (lce_req_ready_and_o),
        .enq_v       (enq_v_s),
        .buf_full    (buf_full_s),
        .v_o         (lce_req_v_o),
        .ready_and_i (lce_req_ready_and_i),
        .src_o       (lce_req_src_o),
        .header_o    (lce_req_header_o),
        .data_o      (lce_req_data_o)
    );

endmodule

// File: tb/tb_bp_core_lce_req_arbiter.sv
// Randomized and directed bench for the LCE request arbiter, checked every cycle
// against a queue-based model of the arbitration, buffering and counter rules.
module tb_bp_core_lce_req_arbiter;

    localparam int HW = 16;
    localparam int DW = 32;
    localparam int CW = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               fp = 1'b0;
    logic [1:0][HW-1:0] hdr_in = '0;
    logic [1:0][DW-1:0] dat_in = '0;
    logic [1:0]         v_in = 2'b00;
    logic [1:0]         rdy_o;
    logic [HW-1:0]      hdr_o;
    logic [DW-1:0]      dat_o;
    logic               src_o;
    logic               v_o;
    logic               noc_rdy = 1'b0;
    logic [CW-1:0]      cnt_o;
    logic               clr = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic          src;
        logic [HW-1:0] hdr;
        logic [DW-1:0] dat;
    } ent_t;

    ent_t       q[$];
    ent_t       e;
    logic       m_rr;
    int         m_cnt;
    int         n;
    logic [1:0] er;

    bp_core_lce_req_arbiter #(
        .header_width_p (HW),
        .data_width_p   (DW),
        .cnt_width_p    (CW)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (rst_n),
        .fixed_priority_i    (fp),
        .lce_req_header_i    (hdr_in),
        .lce_req_data_i      (dat_in),
        .lce_req_v_i         (v_in),
        .lce_req_ready_and_o (rdy_o),
        .lce_req_header_o    (hdr_o),
        .lce_req_data_o      (dat_o),
        .lce_req_src_o       (src_o),
        .lce_req_v_o         (v_o),
        .lce_req_ready_and_i (noc_rdy),
        .conflict_cnt_o      (cnt_o),
        .conflict_clr_i      (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: compare at the falling edge with the pre-edge state, then advance to the post-edge state
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_rr  = 1'b0;
            m_cnt = 0;
            er    = 2'b00;
            n     = 0;
        end else begin
            n  = q.size();
            er = 2'b00;
            if (n < 2) begin
                if (v_in == 2'b01) er = 2'b01;
                else if (v_in == 2'b10) er = 2'b10;
                else if (v_in == 2'b11) er = (fp || m_rr) ? 2'b10 : 2'b01;
            end
        end
        chk("ready", 64'(rdy_o), 64'(er));
        chk("v_o", 64'(v_o), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("src", 64'(src_o), 64'(q[0].src));
            chk("hdr", 64'(hdr_o), 64'(q[0].hdr));
            chk("dat", 64'(dat_o), 64'(q[0].dat));
        end
        chk("cnt", 64'(cnt_o), 64'(m_cnt));
        if (rst_n) begin
            if (q.size() != 0 && noc_rdy) void'(q.pop_front());
            if (er != 2'b00) begin
                e.src = er[1];
                e.hdr = hdr_in[er[1]];
                e.dat = dat_in[er[1]];
                q.push_back(e);
                m_rr = ~er[1];
            end
            if (clr) m_cnt = 0;
            else if (v_in == 2'b11 && n < 2 && m_cnt != 15) m_cnt = m_cnt + 1;
        end
    end

    initial begin
        // Reset held with both sources requesting and the NoC ready
        v_in = 2'b11;
        noc_rdy = 1'b1;
        hdr_in[0] = 16'hA000;
        hdr_in[1] = 16'hD000;
        dat_in[0] = 32'h1111_0000;
        dat_in[1] = 32'h2222_0000;
        repeat (3) step();
        chk("rst_ready", 64'(rdy_o), 64'h0);
        chk("rst_v", 64'(v_o), 64'h0);
        #2 rst_n = 1'b1;
        #1 chk("first_grant", 64'(rdy_o), 64'h1);
        step();
        chk("first_src", 64'(src_o), 64'h0);
        chk("first_hdr", 64'(hdr_o), 64'hA000);

        // Clear together with a conflict, then 8 alternating round-robin grants
        clr = 1'b1;
        #1 chk("rr_pre", 64'(rdy_o), 64'h2);
        step();
        clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_alt", 64'(rdy_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            step();
        end
        chk("rr_cnt8", 64'(cnt_o), 64'h8);

        // D$ priority mode
        fp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("fp_d", 64'(rdy_o), 64'h2);
            step();
        end
        v_in = 2'b01;
        #1 chk("fp_i", 64'(rdy_o), 64'h1);
        step();
        fp = 1'b0;
        v_in = 2'b00;
        repeat (3) step();

        // Backpressure: A and B fill the buffer, C stalls
        noc_rdy = 1'b0;
        v_in = 2'b01;
        hdr_in[0] = 16'h0A0A;
        step();
        hdr_in[0] = 16'h0B0B;
        step();
        hdr_in[0] = 16'h0C0C;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_stall", 64'(rdy_o), 64'h0);
            chk("bp_hold", 64'(hdr_o), 64'h0A0A);
            step();
        end
        noc_rdy = 1'b1;
        #1 chk("bp_full_deq", 64'(rdy_o), 64'h0);
        step();
        chk("bp_b", 64'(hdr_o), 64'h0B0B);
        chk("bp_c_acc", 64'(rdy_o), 64'h1);
        step();
        chk("bp_c", 64'(hdr_o), 64'h0C0C);
        v_in = 2'b00;
        repeat (3) step();

        // Counter saturation and clear-over-increment
        clr = 1'b1;
        step();
        clr = 1'b0;
        v_in = 2'b11;
        repeat (20) step();
        chk("sat", 64'(cnt_o), 64'hF);
        clr = 1'b1;
        step();
        chk("clr", 64'(cnt_o), 64'h0);
        clr = 1'b0;

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            v_in = 2'($urandom);
            fp = ($urandom_range(0, 3) == 0);
            noc_rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            hdr_in[0] = HW'($urandom);
            hdr_in[1] = HW'($urandom);
            dat_in[0] = $urandom;
            dat_in[1] = $urandom;
            step();
        end

        // Asynchronous reset with two buffered entries
        clr = 1'b0;
        fp = 1'b0;
        noc_rdy = 1'b0;
        v_in = 2'b01;
        step();
        step();
        step();
        chk("pre_arst_v", 64'(v_o), 64'h1);
        #2 rst_n = 1'b0;
        #1 chk("arst_v", 64'(v_o), 64'h0);
        chk("arst_ready", 64'(rdy_o), 64'h0);
        step();
        step();
        v_in = 2'b11;
        #2 rst_n = 1'b1;
        #1 chk("post_rr", 64'(rdy_o), 64'h1);
        chk("post_v", 64'(v_o), 64'h0);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_core_lce_req_arbiter.md
Name: bp_core_lce_req_arbiter

Overview:
Merges the core's two LCE request channels onto one coherence-network request port. Index 0 is the I$ LCE and index 1 is the D$ LCE.
- Arbitration is round-robin, or fixed priority to the D$ under a mode input.
- A registered 2-entry output buffer cuts the combinational path into the NoC.
- Each emitted request is tagged with its source index.
- The block sits between the core's per-cache lce_req outputs and the single-port coherence NoC adapter.

Parameters:
header_width_p, 64, width of one LCE request header (lce_req_header_width_lp at instantiation)
data_width_p, 512, width of the request data field (cce_block_width_p at instantiation)
cnt_width_p, 16, width of the saturating conflict counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous, active-low reset
fixed_priority_i  in  1  1 = D$ (index 1) always wins; 0 = round-robin
lce_req_header_i  in  2 x header_width_p  per-source request headers
lce_req_data_i  in  2 x data_width_p  per-source request data
lce_req_v_i  in  2  per-source valid
lce_req_ready_and_o  out  2  per-source ready; transfer on v & ready_and
lce_req_header_o  out  header_width_p  merged header
lce_req_data_o  out  data_width_p  merged data
lce_req_src_o  out  1  source index of the current output entry
lce_req_v_o  out  1  output valid
lce_req_ready_and_i  in  1  NoC ready; transfer on v_o & ready_and_i
conflict_cnt_o  out  cnt_width_p  cycles in which both sources were valid and the buffer was not full; saturating
conflict_clr_i  in  1  synchronous clear of conflict_cnt_o

Behaviour:
Reset (reset_n_i = 0, asynchronous):
- buffer empty; lce_req_v_o = 0
- lce_req_ready_and_o = 2'b00 while reset is held
- rr pointer = 0 (I$ preferred first); conflict_cnt_o = 0
- Header, data and src outputs are don't-care while v_o = 0.

Grant (combinational, only when buffer not full):
- Exactly one source valid: grant that source.
- Both valid and fixed_priority_i = 1: grant index 1.
- Both valid and fixed_priority_i = 0: grant index rr_ptr.
- Buffer full: no grant.
- lce_req_ready_and_o[i] = grant[i]. It may depend combinationally on lce_req_v_i, since LCEs assert v independently of ready.
- At most one ready_and_o bit is high in any cycle.

Round-robin pointer:
- On an accepted grant to source i, rr_ptr <= ~i, in both modes.
- The pointer is unchanged if there is no grant.
- Toggling fixed_priority_i takes effect the same cycle; no state is flushed.

Buffer (2-entry FIFO of {src, header, data}):
- Enqueue on any granted transfer; dequeue on lce_req_v_o & lce_req_ready_and_i.
- Order is preserved and there is no bypass. A request accepted in cycle N is presented at the earliest in cycle N+1.
- Sustained throughput is 1 request/cycle when the NoC is always ready.
- Full: ready_and_o = 0, even if a dequeue occurs the same cycle. The next acceptance happens the cycle after the dequeue.
- Empty with enqueue: v_o = 1 next cycle.
- Simultaneous enqueue and dequeue with occupancy 1: occupancy stays 1 and the new entry becomes the head next cycle.
- Read and write pointers are 1-bit and wrap.
- Output fields stay stable while v_o = 1 and ready_and_i = 0.

Conflict counter:
- Increments when lce_req_v_i = 2'b11 and the buffer is not full, and saturates at all-ones.
- conflict_clr_i has priority over increment and zeroes the counter next cycle.

Reset mid-operation:
- Buffered entries are discarded and v_o drops immediately (asynchronously).
- Upstream LCEs retain their requests because the handshake never completed.

Assertions (simulation only):
- ready_and_o never 2'b11.
- No enqueue when full.
- Output stable under backpressure.

Decomposition:
- Shared package bp_top_pkg: typedef for the buffer entry struct {src, header, data}; localparam lce_req_src_width_gp = 1.
- Sub-module bp_lce_req_two_fifo: 2-entry FIFO with asynchronous active-low reset, valid/ready_and on both sides, entry width parameterised.
- The arbiter top holds only the grant logic, rr_ptr and the counter.

Test Plan:
- Reset with both v_i = 1 and NoC ready: during reset, ready_and_o = 00 and v_o = 0. First cycle after release: ready_and_o = 01 (I$). Next cycle the output shows src = 0 and the I$ header.
- Both sources continuously valid, rr mode, NoC always ready: grants alternate 0,1,0,1 for 8 cycles; conflict_cnt_o = 8; output src sequence 0,1,0,1 delayed by 1 cycle.
- fixed_priority_i = 1, both valid for 4 cycles: ready_and_o = 10 every cycle. Then drop v_i[1]: the I$ is granted the next cycle.
- NoC ready_and_i = 0 with I$ issuing headers A, B, C: A and B accepted, buffer full, C stalls with ready_and_o = 00. With ready_i held low 5 cycles, output A stays stable. Raising ready_and_i emits A then B; C is accepted the cycle after A dequeues.
- Counter saturation (cnt_width_p = 4): 20 conflict cycles -> conflict_cnt_o = 15. Assert conflict_clr_i concurrently with a conflict -> 0 next cycle.
- Assert reset_n_i low asynchronously mid-cycle with 2 buffered entries: v_o falls without waiting for a clock edge; after release, the buffer is empty and rr_ptr = 0.
